core_issue_ctrl: RTL and testbench

- Backend end of the frontend issue interface. Each cycle it takes up to two decoded instructions, offered as inst_valid and inst.
- It decides which of them issue, based on a per-register in-flight writer scoreboard and the backend stall, and returns the issue[1:0] acknowledge that the frontend uses to advance its issue window.
- Issued instructions go into a registered read-stage slot feeding register-file read and execute.

---
 rtl/core_issue_ctrl_pkg.sv | 28 ++
 rtl/core_scoreboard.sv | 82 ++++++++
 rtl/core_issue_ctrl.sv | 76 +++++++
 tb/tb_core_issue_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_issue_ctrl_pkg.sv
// Shared types for the issue controller: decoded instruction package,
// scoreboard counter type and issue mask.
package core_issue_ctrl_pkg;

    localparam int unsigned SB_REGS  = 32;
    localparam int unsigned SB_CNT_W = 2;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;
    typedef logic [1:0]          issue_mask_t;
    typedef logic [4:0]          reg_idx_t;

    typedef struct packed {
        reg_idx_t [1:0] r_reg;
        reg_idx_t       w_reg;
    } reg_info_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        reg_info_t   reg_info;
    } inst_t;

    // Register 0 is hardwired and never takes part in hazard tracking.
    function automatic logic tracked(input reg_idx_t r);
        return r != '0;
    endfunction

endpackage

// File: rtl/core_scoreboard.sv
// Per-register in-flight writer counters with combinational busy/full lookup,
// two increment ports, two release ports and a sticky error flag.
module core_scoreboard
    import core_issue_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  reg_idx_t [3:0] src_reg,
    output logic [3:0]     src_busy,
    input  reg_idx_t [1:0] wr_reg,
    output logic [1:0]     wr_full,
    output logic [1:0]     wr_near_full,
    input  logic [1:0]     inc_valid,
    input  reg_idx_t [1:0] inc_reg,
    input  logic [1:0]     rel_valid,
    input  reg_idx_t [1:0] rel_reg,
    output logic           err
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR  = CNT_W'((1 << CNT_W) - 2);
    localparam int               CNT_MAX_I = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt     [SB_REGS];
    logic [CNT_W-1:0] cnt_nxt [SB_REGS];
    logic             err_nxt;
    int               level;
    int               up;
    int               dn;

    always_comb begin
        src_busy     = '0;
        wr_full      = '0;
        wr_near_full = '0;
        for (int unsigned i = 0; i < 4; i++)
            src_busy[i] = tracked(src_reg[i]) && (cnt[src_reg[i]] != '0);
        // near_full means a second same-cycle increment would not fit
        for (int unsigned i = 0; i < 2; i++) begin
            wr_full[i]      = tracked(wr_reg[i]) && (cnt[wr_reg[i]] == CNT_MAX);
            wr_near_full[i] = tracked(wr_reg[i]) && (cnt[wr_reg[i]] >= CNT_NEAR);
        end
    end

    always_comb begin
        err_nxt    = err;
        level      = 0;
        up         = 0;
        dn         = 0;
        cnt_nxt[0] = '0;
        for (int unsigned r = 1; r < SB_REGS; r++) begin
            up = 0;
            dn = 0;
            for (int unsigned k = 0; k < 2; k++) begin
                if (inc_valid[k] && inc_reg[k] == 5'(r)) up = up + 1;
                if (rel_valid[k] && rel_reg[k] == 5'(r)) dn = dn + 1;
            end
            level = int'(cnt[r]) + up - dn;
            if (level < 0) begin
                cnt_nxt[r] = '0;
                err_nxt    = 1'b1;
            end else if (level > CNT_MAX_I) begin
                cnt_nxt[r] = CNT_MAX;
                err_nxt    = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(level);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < SB_REGS; r++) cnt[r] <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            err <= err_nxt;
        end
    end

endmodule

// File: rtl/core_issue_ctrl.sv
// In-order dual-issue acceptance against the writer scoreboard, plus the
// registered read-stage slot.
module core_issue_ctrl
    import core_issue_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = SB_CNT_W,
    parameter bit          DUAL_ISSUE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     inst_valid_i,
    input  inst_t [1:0]    inst_i,
    output issue_mask_t    issue_o,
    input  logic           rst_jmp_i,
    input  logic           stall_i,
    input  logic [1:0]     wb_valid_i,
    input  reg_idx_t [1:0] wb_reg_i,
    output logic [1:0]     is_valid_o,
    output inst_t [1:0]    is_inst_o,
    output logic           sb_err_o
);

    reg_idx_t   w0, w1;
    logic [3:0] src_busy;
    logic [1:0] wr_full;
    logic [1:0] wr_near_full;
    logic       raw_hit;
    logic       same_wr;
    logic       issue0;
    logic       issue1;

    assign w0 = inst_i[0].reg_info.w_reg;
    assign w1 = inst_i[1].reg_info.w_reg;

    core_scoreboard #(.CNT_W(CNT_W)) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_reg      ({inst_i[1].reg_info.r_reg[1], inst_i[1].reg_info.r_reg[0],
                        inst_i[0].reg_info.r_reg[1], inst_i[0].reg_info.r_reg[0]}),
        .src_busy     (src_busy),
        .wr_reg       ({w1, w0}),
        .wr_full      (wr_full),
        .wr_near_full (wr_near_full),
        .inc_valid    (issue_o),
        .inc_reg      ({w1, w0}),
        .rel_valid    (wb_valid_i),
        .rel_reg      (wb_reg_i),
        .err          (sb_err_o)
    );

    // Slot 1 must see slot 0's write as both a RAW hazard and a pending increment.
    always_comb begin
        raw_hit = tracked(w0) && (inst_i[1].reg_info.r_reg[0] == w0 ||
                                  inst_i[1].reg_info.r_reg[1] == w0);
        same_wr = tracked(w1) && (w1 == w0);
        issue0  = rst_n && inst_valid_i[0] && !stall_i && !rst_jmp_i &&
                  !src_busy[0] && !src_busy[1] && !wr_full[0];
        issue1  = DUAL_ISSUE && issue0 && inst_valid_i[1] &&
                  !src_busy[2] && !src_busy[3] && !raw_hit &&
                  (same_wr ? !wr_near_full[1] : !wr_full[1]);
        issue_o = {issue1, issue0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_valid_o <= '0;
            is_inst_o  <= '0;
        end else if (rst_jmp_i) begin
            is_valid_o <= '0;
        end else if (!stall_i) begin
            is_valid_o <= issue_o;
            is_inst_o  <= inst_i;
        end
    end

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl: issue rules, scoreboard counting,
// stall/flush behaviour, underflow error and asynchronous reset.
module tb_core_issue_ctrl;
    import core_issue_ctrl_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     inst_valid;
    inst_t [1:0]    inst;
    issue_mask_t    issue;
    logic           rst_jmp;
    logic           stall;
    logic [1:0]     wb_valid;
    reg_idx_t [1:0] wb_reg;
    logic [1:0]     is_valid;
    inst_t [1:0]    is_inst;
    logic           sb_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_issue_ctrl #(.CNT_W(2), .DUAL_ISSUE(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid_i (inst_valid),
        .inst_i       (inst),
        .issue_o      (issue),
        .rst_jmp_i    (rst_jmp),
        .stall_i      (stall),
        .wb_valid_i   (wb_valid),
        .wb_reg_i     (wb_reg),
        .is_valid_o   (is_valid),
        .is_inst_o    (is_inst),
        .sb_err_o     (sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic inst_t mk(input reg_idx_t r1, input reg_idx_t r0,
                                 input reg_idx_t w, input logic [31:0] pc);
        inst_t t;
        t = '0;
        t.pc = pc;
        t.reg_info.r_reg[1] = r1;
        t.reg_info.r_reg[0] = r0;
        t.reg_info.w_reg = w;
        return t;
    endfunction

    task automatic idle();
        inst_valid = 2'b00;
        inst       = '0;
        wb_valid   = 2'b00;
        wb_reg     = '0;
        stall      = 1'b0;
        rst_jmp    = 1'b0;
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        inst_valid = 2'b11;
        #1;
        chk("reset_issue", 32'(issue), 0);
        chk("reset_is_valid", 32'(is_valid), 0);
        chk("reset_sb_err", 32'(sb_err), 0);
        chk("reset_is_inst", 32'(is_inst[0].pc), 0);
        step();
        step();
        rst_n = 1'b1;
        idle();
        #1;

        // dual issue of independent writers
        inst[0] = mk(0, 0, 5, 32'h100);
        inst[1] = mk(0, 0, 6, 32'h104);
        inst_valid = 2'b11;
        #1 chk("dual_issue", 32'(issue), 3);
        step();
        chk("dual_is_valid", 32'(is_valid), 3);
        chk("dual_cnt5", 32'(dut.u_sb.cnt[5]), 1);
        chk("dual_cnt6", 32'(dut.u_sb.cnt[6]), 1);
        chk("dual_is_pc1", is_inst[1].pc, 32'h104);
        idle();
        wb_valid = 2'b11; wb_reg[0] = 5; wb_reg[1] = 6;
        step();
        chk("rel_cnt5", 32'(dut.u_sb.cnt[5]), 0);
        chk("rel_is_valid", 32'(is_valid), 0);

        // RAW between slots, then blocked until writeback is visible
        idle();
        inst[0] = mk(0, 0, 5, 32'h200);
        inst[1] = mk(0, 5, 10, 32'h204);
        inst_valid = 2'b11;
        #1 chk("raw_issue", 32'(issue), 1);
        step();
        idle();
        inst[0] = mk(0, 5, 10, 32'h204);
        inst_valid = 2'b01;
        #1 chk("raw_blocked", 32'(issue), 0);
        step();
        wb_valid = 2'b01; wb_reg[0] = 5;
        #1 chk("raw_no_bypass", 32'(issue), 0);
        step();
        wb_valid = 2'b00;
        #1 chk("raw_after_wb", 32'(issue), 1);
        step();
        chk("raw_cnt10", 32'(dut.u_sb.cnt[10]), 1);
        chk("raw_is_valid", 32'(is_valid), 1);
        idle();
        wb_valid = 2'b01; wb_reg[0] = 10;
        step();

        // writer saturation on reg 7
        idle();
        inst[0] = mk(0, 0, 7, 32'h300);
        inst[1] = mk(0, 0, 7, 32'h304);
        inst_valid = 2'b11;
        #1 chk("w7_pair", 32'(issue), 3);
        step();
        #1 chk("w7_pair_limit", 32'(issue), 1);
        step();
        chk("w7_cnt3", 32'(dut.u_sb.cnt[7]), 3);
        inst_valid = 2'b01;
        #1 chk("w7_full", 32'(issue), 0);
        step();
        chk("w7_no_err", 32'(sb_err), 0);
        wb_valid = 2'b01; wb_reg[0] = 7;
        #1 chk("w7_full_wb_cycle", 32'(issue), 0);
        step();
        wb_valid = 2'b00;
        #1 chk("w7_after_rel", 32'(issue), 1);
        step();
        chk("w7_cnt_back3", 32'(dut.u_sb.cnt[7]), 3);
        idle();
        wb_valid = 2'b11; wb_reg[0] = 7; wb_reg[1] = 7;
        step();
        chk("w7_double_rel", 32'(dut.u_sb.cnt[7]), 1);
        wb_valid = 2'b01;
        step();
        chk("w7_cleared", 32'(dut.u_sb.cnt[7]), 0);

        // stall hold, then flush during stall
        idle();
        inst[0] = mk(0, 0, 12, 32'hA00);
        inst[1] = mk(0, 0, 13, 32'hA04);
        inst_valid = 2'b11;
        step();
        chk("pre_stall_valid", 32'(is_valid), 3);
        inst[0] = mk(0, 0, 14, 32'hB00);
        inst[1] = mk(0, 0, 15, 32'hB04);
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk("stall_issue", 32'(issue), 0);
            step();
            chk("stall_hold_pc", is_inst[0].pc, 32'hA00);
            chk("stall_hold_valid", 32'(is_valid), 3);
        end
        rst_jmp = 1'b1;
        #1 chk("flush_issue", 32'(issue), 0);
        step();
        chk("flush_is_valid", 32'(is_valid), 0);
        chk("flush_cnt12", 32'(dut.u_sb.cnt[12]), 1);
        chk("flush_cnt13", 32'(dut.u_sb.cnt[13]), 1);
        chk("flush_cnt14", 32'(dut.u_sb.cnt[14]), 0);
        idle();
        wb_valid = 2'b11; wb_reg[0] = 12; wb_reg[1] = 13;
        step();

        // net-out of increment against double release, then underflow
        idle();
        inst[0] = mk(0, 0, 9, 32'hC00);
        inst_valid = 2'b01;
        step();
        chk("r9_cnt1", 32'(dut.u_sb.cnt[9]), 1);
        wb_valid = 2'b11; wb_reg[0] = 9; wb_reg[1] = 9;
        #1 chk("r9_issue", 32'(issue), 1);
        step();
        chk("r9_net_zero", 32'(dut.u_sb.cnt[9]), 0);
        chk("r9_no_err", 32'(sb_err), 0);
        idle();
        wb_valid = 2'b01; wb_reg[0] = 9;
        step();
        chk("r9_underflow_err", 32'(sb_err), 1);
        chk("r9_clamped", 32'(dut.u_sb.cnt[9]), 0);
        idle();
        step();
        chk("r9_err_sticky", 32'(sb_err), 1);

        // asynchronous reset mid-stream
        inst[0] = mk(0, 0, 20, 32'hD00);
        inst[1] = mk(0, 0, 21, 32'hD04);
        inst_valid = 2'b11;
        step();
        chk("pre_rst_cnt20", 32'(dut.u_sb.cnt[20]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_is_valid", 32'(is_valid), 0);
        chk("async_issue", 32'(issue), 0);
        chk("async_cnt20", 32'(dut.u_sb.cnt[20]), 0);
        chk("async_cnt21", 32'(dut.u_sb.cnt[21]), 0);
        chk("async_err", 32'(sb_err), 0);
        step();
        #2 rst_n = 1'b1;
        idle();
        inst[0] = mk(0, 20, 22, 32'hE00);
        inst_valid = 2'b01;
        #1 chk("post_rst_issue", 32'(issue), 1);
        step();
        chk("post_rst_is_valid", 32'(is_valid), 1);
        chk("post_rst_pc", is_inst[0].pc, 32'hE00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
